// File: rtl/du_lod_divider.sv
// ---------------------------------------------------------------------------
// du_lod_divider
//
// Purpose:
//   Iterative unsigned Q48.16 divider for the GELU division unit.
//   quot = floor((num << FRAC) / den), saturated to all-ones on overflow
//   or on a zero denominator. Leading-one positions of the two operands
//   decide how many quotient bits can be non-zero, so the restoring loop
//   runs only s+1 iterations (s = lod(num<<FRAC) - lod(den)) instead of a
//   fixed W+FRAC.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   in_valid     in   operands valid
//   in_ready     out  block can accept operands (high only in IDLE)
//   num          in   W-bit unsigned Q48.16 numerator
//   den          in   W-bit unsigned Q48.16 denominator
//   out_valid    out  result valid (held until out_ready)
//   out_ready    in   consumer accepts result
//   quot         out  W-bit unsigned Q48.16 quotient
//   div_by_zero  out  den was zero for this transaction
//   overflow     out  quotient saturated to all-ones
//
// Also contains du_lod, the leading-one detector that feeds the divider.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// du_lod
//
// Purpose:
//   Leading-one detector: position of the most significant set bit.
//
// Ports:
//   d     in   W-bit operand
//   pos   out  index of the highest set bit (0 when d is zero)
//   zero  out  d is all zeros
// ---------------------------------------------------------------------------
module du_lod #(
   parameter int W  = 64,
   parameter int PW = $clog2(W)
) (
   input  logic [W-1:0]  d,
   output logic [PW-1:0] pos,
   output logic          zero
);

   // Ascending scan: the last set bit seen is the highest one.
   always_comb begin
      pos = '0;
      for (int k = 0; k < W; k++) begin
         if (d[k]) begin
            pos = PW'(k);
         end
      end
   end

   assign zero = (d == '0);

endmodule

module du_lod_divider #(
   parameter int W    = 64,
   parameter int FRAC = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] num,
   input  logic [W-1:0] den,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] quot,
   output logic         div_by_zero,
   output logic         overflow
);

   localparam int NW = W + FRAC;          // dividend width (num << FRAC)
   localparam int PW = $clog2(W);         // LOD position width
   localparam int AW = $clog2(NW);        // width of a, b and s
   localparam int IW = $clog2(W + 1);     // iteration index 0..W

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      DIV,
      DONE
   } state_t;

   state_t          state_reg;
   logic [W-1:0]    num_reg;
   logic [W-1:0]    den_reg;
   logic [NW-1:0]   r_reg;        // partial remainder
   logic [NW:0]     dsh_reg;      // shifted divisor, one bit wider than R
   logic [W:0]      q_reg;        // quotient accumulator incl. overflow bit
   logic [IW-1:0]   i_reg;        // bit position being resolved
   logic            in_ready_reg;
   logic            out_valid_reg;
   logic [W-1:0]    quot_reg;
   logic            dbz_reg;
   logic            ovf_reg;

   // -----------------------------------------------------------------------
   // Leading-one detection on the latched operands
   // -----------------------------------------------------------------------
   logic [PW-1:0] num_pos;
   logic [PW-1:0] den_pos;
   logic          num_zero;
   logic          den_zero;

   du_lod #(.W(W), .PW(PW)) u_lod_num (
      .d    (num_reg),
      .pos  (num_pos),
      .zero (num_zero)
   );

   du_lod #(.W(W), .PW(PW)) u_lod_den (
      .d    (den_reg),
      .pos  (den_pos),
      .zero (den_zero)
   );

   // a is the leading-one position of the dividend, b that of the divisor.
   // The quotient has at most s+1 significant bits; s is only meaningful
   // when a >= b.
   logic [AW-1:0] lod_a;
   logic [AW-1:0] lod_b;
   logic [AW-1:0] shift_s;
   logic          a_lt_b;

   assign lod_a   = AW'(num_pos) + AW'(FRAC);
   assign lod_b   = AW'(den_pos);
   assign a_lt_b  = (lod_a < lod_b);
   assign shift_s = lod_a - lod_b;

   // -----------------------------------------------------------------------
   // One restoring-division step
   // -----------------------------------------------------------------------
   logic          step_ge;
   logic [NW-1:0] r_next;
   logic [W:0]    q_next;

   // When step_ge holds, dsh_reg <= r_reg < 2**NW, so its top bit is zero
   // and the subtraction can be done at NW bits.
   always_comb begin
      step_ge = ({1'b0, r_reg} >= dsh_reg);
      r_next  = r_reg;
      q_next  = q_reg;
      if (step_ge) begin
         r_next = r_reg - dsh_reg[NW-1:0];
         q_next = q_reg | ((W+1)'(1) << i_reg);
      end
   end

   // -----------------------------------------------------------------------
   // Control FSM with registered outputs
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         num_reg       <= '0;
         den_reg       <= '0;
         r_reg         <= '0;
         dsh_reg       <= '0;
         q_reg         <= '0;
         i_reg         <= '0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         quot_reg      <= '0;
         dbz_reg       <= 1'b0;
         ovf_reg       <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  num_reg      <= num;
                  den_reg      <= den;
                  dbz_reg      <= 1'b0;
                  ovf_reg      <= 1'b0;
                  in_ready_reg <= 1'b0;
                  state_reg    <= NORM;
               end
            end

            NORM: begin
               // den==0 is tested first so that 0/0 saturates with
               // div_by_zero rather than returning zero.
               if (den_zero) begin
                  quot_reg      <= '1;
                  dbz_reg       <= 1'b1;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end else if (num_zero || a_lt_b) begin
                  quot_reg      <= '0;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end else if (shift_s >= AW'(W + 1)) begin
                  // Quotient is at least 2**W: cannot be represented.
                  quot_reg      <= '1;
                  ovf_reg       <= 1'b1;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end else begin
                  r_reg     <= {num_reg, {FRAC{1'b0}}};
                  dsh_reg   <= (NW+1)'(den_reg) << shift_s;
                  q_reg     <= '0;
                  i_reg     <= IW'(shift_s);
                  state_reg <= DIV;
               end
            end

            DIV: begin
               r_reg   <= r_next;
               q_reg   <= q_next;
               dsh_reg <= dsh_reg >> 1;
               i_reg   <= i_reg - IW'(1);
               if (i_reg == '0) begin
                  if (q_next[W]) begin
                     quot_reg <= '1;
                     ovf_reg  <= 1'b1;
                  end else begin
                     quot_reg <= q_next[W-1:0];
                  end
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end
            end

            default: begin
               out_valid_reg <= 1'b0;
               in_ready_reg  <= 1'b1;
               state_reg     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_reg;
   assign out_valid   = out_valid_reg;
   assign quot        = quot_reg;
   assign div_by_zero = dbz_reg;
   assign overflow    = ovf_reg;

endmodule

// File: tb/tb_du_lod_divider.sv
// ---------------------------------------------------------------------------
// tb_du_lod_divider
//
// Purpose:
//   Self-checking bench for du_lod_divider: directed vector table, hand
//   sequences for backpressure and mid-divide reset, and random operands
//   against an arithmetic reference model (wide division + saturation,
//   latency from leading-one positions).
// ---------------------------------------------------------------------------
module tb_du_lod_divider;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] num;
   logic [63:0] den;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] quot;
   logic        div_by_zero;
   logic        overflow;

   int vectors;
   int miscompares;
   int txn_no;

   du_lod_divider dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .num         (num),
      .den         (den),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quot        (quot),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] n;
      logic [63:0] d;
      logic [63:0] q;
      logic        dz;
      logic        ov;
      int          lat;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic int msb(input logic [63:0] v);
      int p;
      p = -1;
      for (int k = 0; k < 64; k++) begin
         if (v[k]) p = k;
      end
      return p;
   endfunction

   // Reference: exact floor division of num*2^16 by den, saturating.
   task automatic model(input logic [63:0] n, input logic [63:0] d,
                        output logic [63:0] q, output logic dz,
                        output logic ov, output int lat);
      logic [79:0] big;
      logic [79:0] qq;
      int a;
      int b;
      dz = 1'b0;
      ov = 1'b0;
      if (d == 64'd0) begin
         q   = '1;
         dz  = 1'b1;
         lat = 2;
      end else if (n == 64'd0) begin
         q   = '0;
         lat = 2;
      end else begin
         big = {n, 16'h0000};
         qq  = big / {16'h0000, d};
         ov  = (qq[79:64] != 16'h0000);
         q   = ov ? 64'hFFFF_FFFF_FFFF_FFFF : qq[63:0];
         a   = msb(n) + 16;
         b   = msb(d);
         if (a < b)             lat = 2;
         else if (a - b >= 65)  lat = 2;
         else                   lat = a - b + 3;
      end
   endtask

   // Full transaction: accept, measure latency (accept edge = cycle 0),
   // hold out_ready low for 'stall' cycles checking stability, hand off.
   task automatic run_txn(input logic [63:0] n, input logic [63:0] d,
                          input int stall, output logic [63:0] q,
                          output logic dz, output logic ov, output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 300) begin
         @(posedge clk); #1;
         w++;
      end
      chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
      num      = n;
      den      = d;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 300) begin
         @(posedge clk); #1;
         w++;
      end
      chk("out_valid_within_budget", {63'd0, out_valid}, 64'd1);
      lat = w + 1;
      q   = quot;
      dz  = div_by_zero;
      ov  = overflow;
      for (int k = 0; k < stall; k++) begin
         @(posedge clk); #1;
         chk("stall_quot_stable", quot, q);
         chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
         chk("stall_in_ready_low", {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("handoff_in_ready", {63'd0, in_ready}, 64'd1);
      chk("handoff_out_valid_low", {63'd0, out_valid}, 64'd0);
      txn_no++;
      $display("txn %0d num=%h den=%h quot=%h dbz=%b ovf=%b lat=%0d",
               txn_no, n, d, q, dz, ov, lat);
   endtask

   logic [63:0] rq;
   logic        rdz;
   logic        rov;
   int          rlat;
   logic [63:0] eq;
   logic        edz;
   logic        eov;
   int          elat;
   logic [63:0] rn;
   logic [63:0] rd;

   initial begin
      vectors     = 0;
      miscompares = 0;
      txn_no      = 0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      num         = '0;
      den         = '0;

      tbl[0]  = '{64'h10000, 64'h20000, 64'h8000, 1'b0, 1'b0, 18};
      tbl[1]  = '{64'h60000, 64'h30000, 64'h20000, 1'b0, 1'b0, 20};
      tbl[2]  = '{64'h10000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 2};
      tbl[3]  = '{64'h0, 64'h5, 64'h0, 1'b0, 1'b0, 2};
      tbl[4]  = '{64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b0, 2};
      tbl[5]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 2};
      tbl[6]  = '{64'h1000_0000_0000, 64'h1, 64'h1000_0000_0000_0000, 1'b0, 1'b0, 63};
      tbl[7]  = '{64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 2};
      tbl[8]  = '{64'h0001_0000_0000_0000, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 67};
      tbl[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10000, 1'b0, 1'b0, 19};
      tbl[10] = '{64'h1, 64'h10000, 64'h1, 1'b0, 1'b0, 3};
      tbl[11] = '{64'h1, 64'h10001, 64'h0, 1'b0, 1'b0, 3};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_quot", quot, 64'd0);
      chk("reset_div_by_zero", {63'd0, div_by_zero}, 64'd0);
      chk("reset_overflow", {63'd0, overflow}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed vector table
      for (int t = 0; t < 12; t++) begin
         run_txn(tbl[t].n, tbl[t].d, t % 3, rq, rdz, rov, rlat);
         chk($sformatf("tbl%0d_quot", t), rq, tbl[t].q);
         chk($sformatf("tbl%0d_div_by_zero", t), {63'd0, rdz}, {63'd0, tbl[t].dz});
         chk($sformatf("tbl%0d_overflow", t), {63'd0, rov}, {63'd0, tbl[t].ov});
         chk($sformatf("tbl%0d_latency", t), 64'(rlat), 64'(tbl[t].lat));
      end

      // Backpressure: 1.0/2.0 held for 5 cycles, stray in_valid ignored
      num = 64'h10000; den = 64'h20000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int w = 0; w < 40 && !out_valid; w++) begin
         @(posedge clk); #1;
      end
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      num = 64'h30000; den = 64'h10000; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("bp_quot_held", quot, 64'h8000);
         chk("bp_out_valid_held", {63'd0, out_valid}, 64'd1);
         chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("bp_no_ghost_result", {63'd0, out_valid}, 64'd0);
         chk("bp_idle_in_ready", {63'd0, in_ready}, 64'd1);
      end
      txn_no++;
      $display("txn %0d backpressure sequence done", txn_no);

      // Reset in cycle 8 of the 1.0/2.0 divide
      num = 64'h10000; den = 64'h20000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("pre_reset_busy", {63'd0, in_ready}, 64'd0);
      rst = 1'b1;
      #1;
      chk("midreset_in_ready", {63'd0, in_ready}, 64'd1);
      chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("midreset_quot", quot, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk); #1;
         chk("postreset_no_result", {63'd0, out_valid}, 64'd0);
      end
      run_txn(64'h60000, 64'h30000, 1, rq, rdz, rov, rlat);
      chk("postreset_quot", rq, 64'h20000);
      chk("postreset_latency", 64'(rlat), 64'd20);

      // Random operands against the reference model
      for (int t = 0; t < 200; t++) begin
         rn = {$urandom(), $urandom()};
         rn = rn >> $urandom_range(0, 63);
         rd = {$urandom(), $urandom()};
         rd = rd >> $urandom_range(0, 63);
         if ($urandom_range(0, 15) == 0) rn = '0;
         if ($urandom_range(0, 15) == 0) rd = '0;
         model(rn, rd, eq, edz, eov, elat);
         run_txn(rn, rd, $urandom_range(0, 3), rq, rdz, rov, rlat);
         chk($sformatf("rnd%0d_quot", t), rq, eq);
         chk($sformatf("rnd%0d_div_by_zero", t), {63'd0, rdz}, {63'd0, edz});
         chk($sformatf("rnd%0d_overflow", t), {63'd0, rov}, {63'd0, eov});
         chk($sformatf("rnd%0d_latency", t), 64'(rlat), 64'(elat));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/du_lod_divider.md
# du_lod_divider

Iterative unsigned Q48.16 divider for the GELU division unit (DU). It sits directly downstream of the 64-bit leading-one detector and consumes the detector's position outputs. Each transaction takes numerator and denominator through a ready/valid handshake. The block uses leading-one positions to size a restoring-division loop that runs only as many iterations as the quotient can have bits, then returns a saturated Q48.16 quotient.

## Interface
- W, 64, operand and quotient width (Q48.16, 16 fraction bits)
- FRAC, 16, fraction bits; dividend is num << FRAC
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- num  in  W  unsigned Q48.16 numerator
- den  in  W  unsigned Q48.16 denominator
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quot  out  W  unsigned Q48.16 quotient, floor((num<<16)/den)
- div_by_zero  out  1  den was 0 (sticky for the transaction)
- overflow  out  1  quotient saturated to all-ones

One clock domain. Reset is asynchronous and active-high.

## Operation
- Instantiates two LOD units (W=64): one on num, one on den.
- Internal dividend N = {num, 16'b0} (80 bits).
- a = lod_pos(num) + 16 (lod of N). b = lod_pos(den).
- States:
  - IDLE: in_ready=1. in_valid&in_ready latches num and den, then goes to NORM.
  - NORM: one cycle. Reads the LOD outputs and decides:
    - den==0 → quot=all-ones, div_by_zero=1, go to DONE.
    - num==0, or a<b → quot=0, go to DONE.
    - s=a-b ≥ 65 → quot=all-ones, overflow=1, go to DONE.
    - otherwise → R=N, Dsh=den<<s (81 bits), i=s, Q=0, go to DIV.
  - DIV: one quotient bit per cycle.
    - If R ≥ Dsh then R-=Dsh and Q[i]=1.
    - Dsh>>=1, i-=1.
    - After the i=0 step, go to DONE.
    - Q is 65 bits. If Q[64]=1, quot=all-ones and overflow=1; else quot=Q[63:0].
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Precedence in NORM: den==0 is checked before num==0. So 0/0 returns all-ones with div_by_zero=1.
- Arithmetic is exact restoring division. No rounding; the result is truncated toward zero.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, quot=0, div_by_zero=0, overflow=0.
- Accept edge = cycle 0. NORM occupies cycle 1.
- Latency from accept to out_valid:
  - Early-out cases: out_valid is high in cycle 2.
  - Divide cases: out_valid is high in cycle s+3.
- in_ready is high only in IDLE. There is no accept in the same cycle as a result handoff. After out_valid&out_ready, in_ready rises the next cycle.
- quot, div_by_zero and overflow are stable while out_valid=1 and out_ready=0. Flags clear on entry to NORM.
- Reset asserted in any state returns the block to IDLE immediately. Any in-flight transaction is discarded and no out_valid is produced.
- in_valid while busy is ignored. The upstream stage must hold its operands until in_ready.

## Test plan
- num=0x10000 (1.0), den=0x20000 (2.0) → a=32, b=17, s=15. quot=0x8000, flags 0, out_valid in cycle 18.
- num=0x60000 (6.0), den=0x30000 (3.0) → s=17. quot=0x20000, out_valid in cycle 20.
- Early-out cases, each with out_valid in cycle 2:
  - den=0, num=0x10000 → quot=0xFFFFFFFFFFFFFFFF, div_by_zero=1.
  - num=0, den=5 → quot=0, flags 0.
  - num=1, den=0xFFFFFFFFFFFFFFFF (a=16 < b=63) → quot=0.
- Overflow cases:
  - num=0x7FFFFFFFFFFFFFFF, den=1 (s=78) → quot=all-ones, overflow=1, cycle 2.
  - num=0x100000000000, den=0x1 (s=60) → quot=0x1000000000000000, no overflow.
- Backpressure: hold out_ready=0 for 5 cycles on the 1.0/2.0 case → quot stays 0x8000 with out_valid=1. in_ready stays 0 and a second in_valid is ignored. Release out_ready → in_ready=1 the next cycle.
- Reset mid-DIV (cycle 8 of the 1.0/2.0 case) → next cycle in_ready=1, out_valid=0, quot=0. A following 6.0/3.0 transaction still returns 0x20000.
- 200 random num/den pairs with random out_ready stalls → quot matches the floor((num<<16)/den) golden model with saturation. Latency equals s+3 or 2.
